// File: rtl/mor1kx_pic_vec.sv
// mor1kx_pic_vec: programmable interrupt controller for mor1kx. It holds PICMR/PICSR
// on the SPR bus and a registered PICID that reports the lowest pending line.
module mor1kx_pic_vec #(
  parameter int          NUM_IRQ              = 32,
  parameter int          OPTION_PIC_NMI_WIDTH = 0,
  parameter logic [31:0] TRIGGER_EDGE         = 32'h0,
  parameter int          SYNC_STAGES          = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] irq_i,
  input  logic        spr_access_i,
  input  logic        spr_we_i,
  input  logic [15:0] spr_addr_i,
  input  logic [31:0] spr_dat_i,
  output logic        spr_bus_ack,
  output logic [31:0] spr_dat_o,
  output logic [31:0] spr_picmr_o,
  output logic [31:0] spr_picsr_o,
  output logic        irq_o,
  output logic [4:0]  irq_id_o,
  output logic        irq_id_valid_o
);

  localparam logic [63:0] ONE64      = 64'd1;
  localparam logic [31:0] IMPL_MASK  = 32'((ONE64 << NUM_IRQ) - ONE64);
  localparam logic [31:0] NMI_MASK   = 32'((ONE64 << OPTION_PIC_NMI_WIDTH) - ONE64) & IMPL_MASK;
  localparam logic [31:0] EDGE_MASK  = TRIGGER_EDGE & IMPL_MASK;
  localparam logic [31:0] LEVEL_MASK = ~TRIGGER_EDGE & IMPL_MASK;

  localparam logic [10:0] OFF_PICMR = 11'd0;
  localparam logic [10:0] OFF_PICSR = 11'd2;
  localparam logic [10:0] OFF_PICID = 11'd3;

  logic [31:0] r_picmr;
  logic [31:0] r_picsr;
  logic [31:0] r_hist;
  logic        r_irq;
  logic        r_id_valid;
  logic [4:0]  r_id;

  logic [31:0] w_irq_s;
  logic [31:0] w_um;
  logic [31:0] w_set;
  logic [31:0] w_clr;
  logic [31:0] w_picsr_nxt;
  logic [4:0]  w_id;
  logic [10:0] w_off;
  logic        w_wr_picmr;
  logic        w_wr_picsr;
  logic        w_unused_addr;

  assign w_off         = spr_addr_i[10:0];
  assign w_unused_addr = ^spr_addr_i[15:11];
  assign w_wr_picmr    = spr_access_i & spr_we_i & (w_off == OFF_PICMR);
  assign w_wr_picsr    = spr_access_i & spr_we_i & (w_off == OFF_PICSR);

  // Lines may be asynchronous to clk; SYNC_STAGES == 0 is for already-synchronous sources.
  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign w_irq_s = irq_i & IMPL_MASK;
    end else begin : g_sync
      logic [31:0] r_sync [SYNC_STAGES];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < SYNC_STAGES; i++) begin
            r_sync[i] <= '0;
          end
        end else begin
          r_sync[0] <= irq_i & IMPL_MASK;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
          end
        end
      end

      assign w_irq_s = r_sync[SYNC_STAGES-1];
    end
  endgenerate

  assign w_um  = w_irq_s & r_picmr;
  assign w_set = w_um & ~r_hist & EDGE_MASK;
  assign w_clr = w_wr_picsr ? (spr_dat_i & EDGE_MASK) : 32'h0;

  // A new edge is OR'd in after the W1C clear, so a coincident edge survives the write.
  assign w_picsr_nxt = (w_um & LEVEL_MASK) | w_set | (r_picsr & EDGE_MASK & ~w_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_picmr <= NMI_MASK;
    end else if (w_wr_picmr) begin
      r_picmr <= (spr_dat_i | NMI_MASK) & IMPL_MASK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_picsr <= '0;
      r_hist  <= '0;
    end else begin
      r_picsr <= w_picsr_nxt;
      r_hist  <= w_um & EDGE_MASK;
    end
  end

  // Scanning from the top leaves the lowest set index, which has highest priority.
  always_comb begin
    w_id = '0;
    for (int i = 31; i >= 0; i--) begin
      if (r_picsr[i]) begin
        w_id = 5'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq      <= 1'b0;
      r_id_valid <= 1'b0;
      r_id       <= '0;
    end else begin
      r_irq      <= |r_picsr;
      r_id_valid <= |r_picsr;
      r_id       <= w_id;
    end
  end

  always_comb begin
    spr_dat_o = '0;
    if (spr_access_i) begin
      case (w_off)
        OFF_PICMR: spr_dat_o = r_picmr;
        OFF_PICSR: spr_dat_o = r_picsr;
        OFF_PICID: spr_dat_o = {26'b0, r_id_valid, r_id};
        default:   spr_dat_o = '0;
      endcase
    end
  end

  assign spr_bus_ack    = spr_access_i;
  assign spr_picmr_o    = r_picmr;
  assign spr_picsr_o    = r_picsr;
  assign irq_o          = r_irq;
  assign irq_id_o       = r_id;
  assign irq_id_valid_o = r_id_valid;

endmodule

// File: tb/tb_mor1kx_pic_vec.sv
// tb_mor1kx_pic_vec: directed and random checks of mor1kx_pic_vec against a
// behavioural model; a second 8-line instance covers the implemented-width masking.
module tb_mor1kx_pic_vec;

  localparam int          NUM_IRQ  = 32;
  localparam int          NMI      = 2;
  localparam int          SYNC     = 2;
  localparam logic [31:0] EDGE     = 32'hA0F0_0009;
  localparam logic [31:0] IMPL     = 32'hFFFF_FFFF;
  localparam logic [31:0] NMI_MASK = 32'h0000_0003;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        acc   = 1'b0;
  logic        we    = 1'b0;
  logic [15:0] addr  = '0;
  logic [31:0] dat   = '0;
  logic [31:0] irq   = '0;

  logic        spr_bus_ack;
  logic [31:0] spr_dat_o;
  logic [31:0] spr_picmr_o;
  logic [31:0] spr_picsr_o;
  logic        irq_o;
  logic [4:0]  irq_id_o;
  logic        irq_id_valid_o;

  logic        wAck;
  logic [31:0] wDat;
  logic [31:0] wPicmr;
  logic [31:0] wPicsr;
  logic        wIrq;
  logic [4:0]  wId;
  logic        wValid;

  int total = 0;
  int bad   = 0;

  logic [31:0] mPicmr;
  logic [31:0] mPicsr;
  logic [31:0] mHist;
  logic        mIrq;
  logic        mValid;
  logic [4:0]  mId;
  logic [31:0] mSync[$];

  always #5 clk = ~clk;

  mor1kx_pic_vec #(
    .NUM_IRQ(NUM_IRQ), .OPTION_PIC_NMI_WIDTH(NMI), .TRIGGER_EDGE(EDGE), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .irq_i(irq), .spr_access_i(acc), .spr_we_i(we),
    .spr_addr_i(addr), .spr_dat_i(dat), .spr_bus_ack(spr_bus_ack), .spr_dat_o(spr_dat_o),
    .spr_picmr_o(spr_picmr_o), .spr_picsr_o(spr_picsr_o), .irq_o(irq_o),
    .irq_id_o(irq_id_o), .irq_id_valid_o(irq_id_valid_o)
  );

  mor1kx_pic_vec #(
    .NUM_IRQ(8), .OPTION_PIC_NMI_WIDTH(0), .TRIGGER_EDGE(32'h0), .SYNC_STAGES(2)
  ) dutW (
    .clk(clk), .rst_n(rst_n), .irq_i(irq), .spr_access_i(acc), .spr_we_i(we),
    .spr_addr_i(addr), .spr_dat_i(dat), .spr_bus_ack(wAck), .spr_dat_o(wDat),
    .spr_picmr_o(wPicmr), .spr_picsr_o(wPicsr), .irq_o(wIrq),
    .irq_id_o(wId), .irq_id_valid_o(wValid)
  );

  // Reference model: the sync chain is a queue, PICSR follows the per-line rules directly.
  task automatic modelReset();
    mPicmr = NMI_MASK;
    mPicsr = '0;
    mHist  = '0;
    mIrq   = 1'b0;
    mValid = 1'b0;
    mId    = '0;
    mSync  = {};
    repeat (SYNC) mSync.push_back(32'h0);
  endtask

  task automatic modelStep();
    logic [31:0] um;
    logic [31:0] iso;
    um     = mSync[0] & mPicmr;
    mValid = (mPicsr != 0);
    mIrq   = mValid;
    if (mPicsr == 0) begin
      mId = '0;
    end else begin
      iso = mPicsr & (~mPicsr + 32'd1);
      mId = 5'($countones(iso - 32'd1));
    end
    for (int n = 0; n < 32; n++) begin
      if (EDGE[n]) begin
        if (um[n] && !mHist[n]) mPicsr[n] = 1'b1;
        else if (acc && we && addr[10:0] == 11'd2 && dat[n]) mPicsr[n] = 1'b0;
      end else begin
        mPicsr[n] = um[n];
      end
      mHist[n] = um[n];
    end
    if (acc && we && addr[10:0] == 11'd0) mPicmr = (dat | NMI_MASK) & IMPL;
    mSync.push_back(irq & IMPL);
    void'(mSync.pop_front());
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) modelReset();
    else modelStep();
  end

  function automatic logic [31:0] modelRead(input logic a, input logic [15:0] ad);
    if (!a) return 32'h0;
    case (ad[10:0])
      11'd0:   return mPicmr;
      11'd2:   return mPicsr;
      11'd3:   return {26'b0, mValid, mId};
      default: return 32'h0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One bus cycle: check registered state at the falling edge, drive, then check the read path.
  task automatic applyStimulus(input logic a, input logic w, input logic [15:0] ad,
                               input logic [31:0] d, input logic [31:0] ir);
    @(negedge clk);
    checkOutput("picmr", spr_picmr_o, mPicmr);
    checkOutput("picsr", spr_picsr_o, mPicsr);
    checkOutput("irq_o", {31'b0, irq_o}, {31'b0, mIrq});
    checkOutput("irq_id", {27'b0, irq_id_o}, {27'b0, mId});
    checkOutput("irq_valid", {31'b0, irq_id_valid_o}, {31'b0, mValid});
    acc  = a;
    we   = w;
    addr = ad;
    dat  = d;
    irq  = ir;
    #1;
    checkOutput("ack", {31'b0, spr_bus_ack}, {31'b0, a});
    checkOutput("dat_o", spr_dat_o, modelRead(a, ad));
  endtask

  initial begin
    logic [31:0] rIrq;
    int          off;

    modelReset();
    $display("[TB] reset");
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_picmr", spr_picmr_o, 32'h3);
    checkOutput("rst_picsr", spr_picsr_o, 32'h0);
    checkOutput("rst_irq_o", {31'b0, irq_o}, 32'h0);
    checkOutput("rst_w_picmr", wPicmr, 32'h0);
    acc  = 1'b1;
    addr = 16'd3;
    #1;
    checkOutput("rst_picid", spr_dat_o, 32'h0);
    acc   = 1'b0;
    rst_n = 1'b1;

    $display("[TB] level line");
    applyStimulus(1, 1, 16'd0, 32'h10, 32'h0);
    applyStimulus(0, 0, 16'd0, 32'h0, 32'h10);
    repeat (3) applyStimulus(1, 0, 16'd3, 32'h0, 32'h10);
    checkOutput("lvl_irq_early", {31'b0, irq_o}, 32'h0);
    checkOutput("lvl_picsr", spr_picsr_o, 32'h10);
    applyStimulus(1, 0, 16'd3, 32'h0, 32'h10);
    checkOutput("lvl_irq_o", {31'b0, irq_o}, 32'h1);
    checkOutput("lvl_picid", spr_dat_o, 32'h24);
    applyStimulus(1, 1, 16'd2, 32'h10, 32'h10);
    applyStimulus(1, 0, 16'd2, 32'h0, 32'h10);
    checkOutput("lvl_w1c_ignored", spr_dat_o, 32'h10);
    applyStimulus(0, 0, 16'd0, 32'h0, 32'h0);
    repeat (3) applyStimulus(0, 0, 16'd0, 32'h0, 32'h0);
    checkOutput("lvl_drop_early", {31'b0, irq_o}, 32'h1);
    applyStimulus(0, 0, 16'd0, 32'h0, 32'h0);
    checkOutput("lvl_drop", {31'b0, irq_o}, 32'h0);

    $display("[TB] edge line");
    applyStimulus(1, 1, 16'd0, 32'h1, 32'h0);
    repeat (2) applyStimulus(0, 0, 16'd0, 32'h0, 32'h0);
    applyStimulus(0, 0, 16'd0, 32'h0, 32'h1);
    applyStimulus(0, 0, 16'd0, 32'h0, 32'h0);
    repeat (2) applyStimulus(0, 0, 16'd0, 32'h0, 32'h0);
    checkOutput("edge_latch", spr_picsr_o, 32'h1);
    repeat (2) applyStimulus(0, 0, 16'd0, 32'h0, 32'h0);
    checkOutput("edge_hold", spr_picsr_o, 32'h1);
    applyStimulus(1, 1, 16'd2, 32'h1, 32'h0);
    applyStimulus(1, 0, 16'd2, 32'h0, 32'h0);
    checkOutput("edge_w1c", spr_dat_o, 32'h0);
    applyStimulus(0, 0, 16'd0, 32'h0, 32'h1);
    applyStimulus(0, 0, 16'd0, 32'h0, 32'h0);
    applyStimulus(1, 1, 16'd2, 32'h1, 32'h0);
    checkOutput("edge_pre_set", spr_picsr_o, 32'h0);
    applyStimulus(0, 0, 16'd0, 32'h0, 32'h0);
    checkOutput("edge_set_wins", spr_picsr_o, 32'h1);

    $display("[TB] priority");
    applyStimulus(1, 1, 16'd0, 32'hFFFF_FFFF, 32'h0);
    applyStimulus(1, 1, 16'd2, 32'hFFFF_FFFF, 32'h0);
    applyStimulus(0, 0, 16'd0, 32'h0, 32'h0010_0088);
    repeat (4) applyStimulus(1, 0, 16'd3, 32'h0, 32'h0010_0088);
    checkOutput("prio_first", spr_dat_o, 32'h23);
    applyStimulus(1, 1, 16'd2, 32'h8, 32'h0010_0088);
    applyStimulus(1, 0, 16'd2, 32'h0, 32'h0010_0088);
    checkOutput("prio_cleared", spr_dat_o, 32'h0010_0080);
    applyStimulus(1, 0, 16'd3, 32'h0, 32'h0010_0088);
    checkOutput("prio_next", spr_dat_o, 32'h27);

    $display("[TB] width");
    applyStimulus(1, 0, 16'd0, 32'h0, 32'hFFFF_FF00);
    checkOutput("w_picmr", wPicmr, 32'hFF);
    checkOutput("w_dat", wDat, 32'hFF);
    checkOutput("w_ack", {31'b0, wAck}, 32'h1);
    repeat (3) applyStimulus(0, 0, 16'd0, 32'h0, 32'hFFFF_FF00);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 16'd0, 32'h0, {$urandom_range(0, 32'hFF_FFFF), 8'h00} | 32'h0100_0000);
      checkOutput("w_upper_ignored", wPicsr, 32'h0);
      checkOutput("w_irq_quiet", {31'b0, wIrq}, 32'h0);
    end
    repeat (4) applyStimulus(0, 0, 16'd0, 32'h0, 32'hFFFF_FF01);
    checkOutput("w_line0", wPicsr, 32'h1);
    applyStimulus(0, 0, 16'd0, 32'h0, 32'hFFFF_FF01);
    checkOutput("w_irq", {31'b0, wIrq}, 32'h1);
    checkOutput("w_id", {27'b0, wId}, 32'h0);
    checkOutput("w_valid", {31'b0, wValid}, 32'h1);

    $display("[TB] random");
    rIrq = $urandom;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) rIrq = $urandom;
      off = $urandom_range(0, 4);
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    {5'($urandom_range(0, 31)), 8'h00, 3'(off)}, $urandom, rIrq);
    end

    $display("[TB] async reset");
    applyStimulus(1, 1, 16'd0, 32'hFFFF_FFFF, 32'h0);
    repeat (4) applyStimulus(0, 0, 16'd0, 32'h0, 32'h0);
    applyStimulus(1, 1, 16'd2, 32'hFFFF_FFFF, 32'h0);
    applyStimulus(0, 0, 16'd0, 32'h0, 32'h5);
    repeat (3) applyStimulus(0, 0, 16'd0, 32'h0, 32'h5);
    checkOutput("ar_picsr", spr_picsr_o, 32'h5);
    applyStimulus(0, 0, 16'd0, 32'h0, 32'h5);
    checkOutput("ar_irq_before", {31'b0, irq_o}, 32'h1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("ar_picmr", spr_picmr_o, 32'h3);
    checkOutput("ar_picsr_rst", spr_picsr_o, 32'h0);
    checkOutput("ar_irq_o", {31'b0, irq_o}, 32'h0);
    checkOutput("ar_id", {27'b0, irq_id_o}, 32'h0);
    checkOutput("ar_valid", {31'b0, irq_id_valid_o}, 32'h0);
    @(negedge clk);
    irq   = 32'h0;
    rst_n = 1'b1;
    repeat (6) applyStimulus(1, 0, 16'd3, 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mor1kx_pic_vec.md
# mor1kx_pic_vec

Parametrised programmable interrupt controller for the mor1kx CPU. It accepts up to 32 external interrupt lines, which may be asynchronous. Lines are synchronised, and each line is qualified as level or edge triggered according to a per-line parameter. The block holds the OR1K PICMR/PICSR registers on the SPR bus and adds a read-only PICID register, which is a registered priority encoder giving the lowest pending line. It sits between the SoC interrupt sources and the mor1kx control/exception unit and drives `irq_o` to the core.

## Interface
- `NUM_IRQ`, 32: number of implemented lines, 1..32. Bits at or above `NUM_IRQ` are tied to 0 in every register and output.
- `OPTION_PIC_NMI_WIDTH`, 0: lines [NMI_WIDTH-1:0] are always unmasked. Must be ≤ `NUM_IRQ`.
- `TRIGGER_EDGE`, 32'h0: per-line mode. Bit = 1 means rising-edge latched; bit = 0 means level.
- `SYNC_STAGES`, 2: flops in each input synchroniser, 0..3. A value of 0 means no synchroniser.
- `clk` in 1: clock. All state changes on the rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `irq_i` in 32: raw interrupt lines, active-high.
- `spr_access_i` in 1: SPR access to the PIC group this cycle.
- `spr_we_i` in 1: the access is a write.
- `spr_addr_i` in 16: SPR address. Only offset bits [10:0] are decoded.
- `spr_dat_i` in 32: SPR write data.
- `spr_bus_ack` out 1: equals `spr_access_i`, combinational.
- `spr_dat_o` out 32: read data.
- `spr_picmr_o` out 32: current PICMR.
- `spr_picsr_o` out 32: current PICSR.
- `irq_o` out 1: registered OR of PICSR.
- `irq_id_o` out 5: registered lowest pending line index.
- `irq_id_valid_o` out 1: registered; 1 when any PICSR bit is set.

## Operation
- **Register map (offset):**
  - 0 = PICMR, read/write.
  - 2 = PICSR, read; a write clears edge bits (W1C).
  - 3 = PICID, read-only. Value = {26'b0, valid, id}, where valid sits at bit 5 and id at [4:0].
  - Any other offset reads 0 and ignores writes.
- **Synchroniser:**
  - `irq_s` = `irq_i` delayed through `SYNC_STAGES` flops.
  - Unmasked vector `um` = `irq_s & PICMR`.
- **Level line:**
  - PICSR[n] is a flop loaded with `um[n]` every cycle.
  - Writes to PICSR have no effect on level lines.
- **Edge line:**
  - A history flop `h[n]` is loaded with `um[n]` every cycle.
  - Set condition: `um[n] & ~h[n]`.
  - Clear condition: a PICSR write with `spr_dat_i[n]` = 1.
  - If set and clear occur in the same cycle, set wins.
  - Otherwise the bit holds its value.
  - Unmasking a line that is already held high produces an edge.
- **PICMR write:**
  - PICMR = {`spr_dat_i`[31:NMI], NMI ones}.
  - The result is then ANDed with the implemented-line mask.
- **PICID:**
  - Each cycle, `irq_id_o` is loaded with the index of the lowest set PICSR bit. Lowest index has highest priority.
  - `irq_id_valid_o` and `irq_o` are loaded with |PICSR.
  - When PICSR = 0, `irq_id_o` is loaded with 0.
- **Read mux:**
  - `spr_dat_o` is selected combinationally from the current register values.
  - `spr_dat_o` is 0 when `spr_access_i` = 0.
- **Reset values:**
  - PICMR = {(32-NMI) zeros, NMI ones}.
  - PICSR, synchronisers, history, `irq_o`, `irq_id_o` and `irq_id_valid_o` are all 0.
  - Reset is asserted asynchronously.
  - After `rst_n` rises, edge history is 0. A line held high through reset that is also unmasked by the NMI bits therefore sets its edge bit on the first post-reset cycle it reaches `um`.

## Timing
- **Raw input to PICSR:**
  - `irq_i` change is visible in `irq_s` after `SYNC_STAGES` clocks.
  - PICSR updates 1 clock later.
  - `irq_o`, `irq_id_o` and `irq_id_valid_o` update 1 clock after that.
  - Total with default parameters = 4 clocks from `irq_i` to `irq_o`.
- **PICMR write:** takes effect in `um` the next cycle. PICSR and `irq_o` follow with the same +1/+2 cycle latency as above.
- **PICSR W1C:** the bit reads 0 the cycle after the write. `irq_o` follows 1 cycle later.
- **Reads:**
  - Same-cycle combinational.
  - A read in the same cycle as a write returns the pre-write value.
- **Acknowledge:** no wait states; `spr_bus_ack` is asserted in the same cycle as `spr_access_i`.

## Test plan
- **Reset:** hold `rst_n`=0 with NMI=2, then release. Require PICMR = 0x3, PICSR = 0, `irq_o` = 0, and `spr_dat_o` at offset 3 = 0.
- **Level line:** write PICMR = 0x10 and hold `irq_i[4]`=1. Require PICSR = 0x10 and, 4 clocks after the `irq_i` rise, `irq_o`=1 and PICID = 0x24. Drop `irq_i[4]`; require `irq_o`=0 after 4 clocks. A W1C write of 0x10 while the line is held leaves PICSR at 0x10.
- **Edge line** (`TRIGGER_EDGE`=0x1, PICMR=0x1): pulse `irq_i[0]` high for 1 cycle. Require PICSR[0] to latch 1 and hold. A write of 0x1 to PICSR clears it on the next cycle. An edge arriving in the same cycle as the W1C write keeps the bit at 1.
- **Priority:** set lines 3, 7 and 20 together with all unmasked. Require PICID = 0x23. Clear line 3 (edge mode); require PICID = 0x27 two cycles later.
- **Width:** with `NUM_IRQ`=8, write PICMR = 0xFFFFFFFF. Require PICMR to read 0xFF, and `irq_i[31:8]` to never affect PICSR.
- **Asynchronous reset mid-operation:** assert `rst_n` low between clock edges while PICSR = 0x5. Require all outputs to return to reset values immediately, without waiting for a clock edge.
